mips_instr_encoder: RTL and testbench

- Inverse of the main control decoder: converts instruction commands (kind + register/immediate fields + absolute target address) into 32-bit MIPS machine words.
- Streams the words into instruction memory at sequential word addresses.
- Loads test programs into the unicycle processor's program memory from a bench or boot loader.
- Internal FIFO decouples command acceptance from memory-write backpressure.

---
 rtl/mips_instr_encoder_pkg.sv | 68 ++++++
 rtl/mips_instr_encoder_fifo.sv | 75 +++++++
 rtl/mips_instr_encoder.sv | 218 +++++++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_instr_encoder_pkg.sv
// mips_isa_pkg: opcode constants, command kinds, field positions, error codes and
// encoder FSM states shared by the instruction encoder and the control decoder.
package mips_isa_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  typedef enum logic [3:0] {
    KIND_R    = 4'd0,
    KIND_ADDI = 4'd1,
    KIND_ORI  = 4'd2,
    KIND_ANDI = 4'd3,
    KIND_LUI  = 4'd4,
    KIND_LW   = 4'd5,
    KIND_SW   = 4'd6,
    KIND_BEQ  = 4'd7,
    KIND_BNE  = 4'd8,
    KIND_J    = 4'd9,
    KIND_JAL  = 4'd10
  } cmd_kind_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_BAD_KIND     = 2'd1,
    ERR_BRANCH_RANGE = 2'd2,
    ERR_JUMP_REGION  = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } enc_state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return (32'(OP_R_TYPE) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
           (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | 32'(funct);
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] idx);
    return (32'(op) << OP_LSB) | 32'(idx);
  endfunction

endpackage

// File: rtl/mips_instr_encoder_fifo.sv
// enc_fifo: synchronous FIFO of {addr, word} with head and head+1 peek ports,
// full/empty/two-or-more flags and a synchronous flush.
module enc_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next,
  output logic             empty,
  output logic             full,
  output logic             multi
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_s;
  logic [AW-1:0]    rd_next_idx_s;
  logic             do_push_s, do_pop_s;

  assign count_s       = wr_ptr_q - rd_ptr_q;
  assign empty         = (count_s == {(AW+1){1'b0}});
  assign full          = (count_s == (AW+1)'(DEPTH));
  assign multi         = (count_s >= (AW+1)'(2));
  assign rd_next_idx_s = rd_ptr_q[AW-1:0] + {{(AW-1){1'b0}}, 1'b1};
  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign next          = mem_q[rd_next_idx_s];
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push_s     = push && (!full || pop);
  assign do_pop_s      = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = {(AW+1){1'b0}};
      rd_ptr_d = {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: turns instruction commands into MIPS words and streams them to
// instruction memory. Define ENC_RANGE_CHECK_EN to enable branch-range/jump-region checks.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0040_0000,
  parameter int          ADDR_W     = 32,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_last,
  input  logic [3:0]        cmd_kind,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic [5:0]        cmd_funct,
  input  logic [15:0]       cmd_imm,
  input  logic [31:0]       cmd_target,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [15:0]       word_count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int ENTRY_W = ADDR_W + 32;

  enc_state_e        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              done_q, done_d, err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [31:0]       pc_plus4_s, br_off_s, enc_word_s;
  logic              kind_bad_s, is_branch_s, is_jump_s, br_fail_s, j_fail_s, cmd_err_s;
  logic              cmd_ready_s, accept_s, push_s, wr_done_s;
  logic [ENTRY_W-1:0] fifo_head_s, fifo_next_s;
  logic              fifo_empty_s, fifo_full_s, fifo_multi_s;

  assign pc_plus4_s = pc_q + 32'd4;
  assign br_off_s   = cmd_target - pc_plus4_s;

  always_comb begin
    enc_word_s  = 32'd0;
    kind_bad_s  = 1'b0;
    is_branch_s = 1'b0;
    is_jump_s   = 1'b0;
    case (cmd_kind)
      KIND_R:    enc_word_s = r_word(cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_funct);
      KIND_ADDI: enc_word_s = i_word(OP_ADDI, cmd_rs, cmd_rt, cmd_imm);
      KIND_ORI:  enc_word_s = i_word(OP_ORI, cmd_rs, cmd_rt, cmd_imm);
      KIND_ANDI: enc_word_s = i_word(OP_ANDI, cmd_rs, cmd_rt, cmd_imm);
      KIND_LUI:  enc_word_s = i_word(OP_LUI, 5'd0, cmd_rt, cmd_imm);
      KIND_LW:   enc_word_s = i_word(OP_LW, cmd_rs, cmd_rt, cmd_imm);
      KIND_SW:   enc_word_s = i_word(OP_SW, cmd_rs, cmd_rt, cmd_imm);
      KIND_BEQ: begin
        enc_word_s  = i_word(OP_BEQ, cmd_rs, cmd_rt, br_off_s[17:2]);
        is_branch_s = 1'b1;
      end
      KIND_BNE: begin
        enc_word_s  = i_word(OP_BNE, cmd_rs, cmd_rt, br_off_s[17:2]);
        is_branch_s = 1'b1;
      end
      KIND_J: begin
        enc_word_s = j_word(OP_J, cmd_target[27:2]);
        is_jump_s  = 1'b1;
      end
      KIND_JAL: begin
        enc_word_s = j_word(OP_JAL, cmd_target[27:2]);
        is_jump_s  = 1'b1;
      end
      default:   kind_bad_s = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Word offset must sign-fit in 16 bits: bits 31..17 of the byte offset all equal.
  assign br_fail_s = is_branch_s &&
                     ((br_off_s[31:17] != {15{br_off_s[31]}}) || (cmd_target[1:0] != 2'b00));
  assign j_fail_s  = is_jump_s &&
                     ((cmd_target[31:28] != pc_plus4_s[31:28]) || (cmd_target[1:0] != 2'b00));
  logic unused_range_s;
  assign unused_range_s = ^br_off_s[1:0];
`else
  assign br_fail_s = 1'b0;
  assign j_fail_s  = 1'b0;
  logic unused_range_s;
  assign unused_range_s = ^{br_off_s[31:18], br_off_s[1:0], cmd_target[31:28], cmd_target[1:0],
                            pc_plus4_s[31:28], is_branch_s, is_jump_s};
`endif

  assign cmd_err_s   = kind_bad_s || br_fail_s || j_fail_s;
  assign cmd_ready_s = (state_q == ST_RUN) && !fifo_full_s && !start;
  assign accept_s    = cmd_valid && cmd_ready_s;
  assign push_s      = accept_s && !cmd_err_s;
  assign wr_done_s   = mem_we_q && mem_ready;

  // The FIFO head stays resident while it sits in the output register; it pops on completion.
  enc_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (start),
    .push  (push_s),
    .wdata ({ADDR_W'(pc_q), enc_word_s}),
    .pop   (wr_done_s && !start),
    .head  (fifo_head_s),
    .next  (fifo_next_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .multi (fifo_multi_s)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    word_count_d = word_count_q;
    done_d       = done_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    if (start) begin
      state_d      = ST_RUN;
      pc_d         = BASE_ADDR;
      mem_we_d     = 1'b0;
      word_count_d = 16'd0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      err_code_d   = ERR_NONE;
    end else begin
      if (push_s) begin
        pc_d = pc_plus4_s;
      end else begin
        pc_d = pc_q;
      end
      if (wr_done_s) begin
        word_count_d = (word_count_q == 16'hFFFF) ? word_count_q : word_count_q + 16'd1;
        mem_we_d     = fifo_multi_s;
        mem_addr_d   = fifo_multi_s ? fifo_next_s[ENTRY_W-1:32] : mem_addr_q;
        mem_wdata_d  = fifo_multi_s ? fifo_next_s[31:0] : mem_wdata_q;
      end else if (!mem_we_q && !fifo_empty_s) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = fifo_head_s[ENTRY_W-1:32];
        mem_wdata_d = fifo_head_s[31:0];
      end else begin
        mem_we_d = mem_we_q;
      end
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_RUN: begin
          if (accept_s && cmd_err_s) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = kind_bad_s ? ERR_BAD_KIND : (br_fail_s ? ERR_BRANCH_RANGE : ERR_JUMP_REGION);
          end else if (accept_s && cmd_last) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: state_d = (fifo_empty_s && !mem_we_q) ? ST_DONE : ST_DRAIN;
        ST_DONE:  state_d = ST_DONE;
        ST_ERR:   state_d = ST_ERR;
        default:  state_d = ST_IDLE;
      endcase
      done_d = (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= BASE_ADDR;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= 32'd0;
      word_count_q <= 16'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign cmd_ready  = cmd_ready_s;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: reference model computes words from the ISA
// rules; a monitor pops expected writes as the memory accepts them.
module tb_mips_instr_encoder;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, cmd_valid = 1'b0, cmd_last = 1'b0, mem_ready = 1'b0;
  logic [3:0]  cmd_kind = 4'd0;
  logic [4:0]  cmd_rs = 5'd0, cmd_rt = 5'd0, cmd_rd = 5'd0, cmd_shamt = 5'd0;
  logic [5:0]  cmd_funct = 6'd0;
  logic [15:0] cmd_imm = 16'd0;
  logic [31:0] cmd_target = 32'd0;
  logic        cmd_ready, mem_we, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] word_count;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  mips_instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_last(cmd_last), .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_funct(cmd_funct), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .done(done), .err(err), .err_code(err_code)
  );

  typedef struct {
    logic [3:0] kind; logic [4:0] rs; logic [4:0] rt; logic [4:0] rd; logic [4:0] shamt;
    logic [5:0] funct; logic [15:0] imm; logic [31:0] target; logic last;
  } cmd_t;
  typedef struct { logic [31:0] addr; logic [31:0] word; } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  logic [31:0] m_pc = BASE;
  int          last_ec = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input int kind, input int rs, input int rt, input int rd,
                              input int sh, input int fn, input int imm,
                              input logic [31:0] tgt, input bit last);
    cmd_t c;
    c.kind = 4'(kind); c.rs = 5'(rs); c.rt = 5'(rt); c.rd = 5'(rd); c.shamt = 5'(sh);
    c.funct = 6'(fn); c.imm = 16'(imm); c.target = tgt; c.last = last;
    return c;
  endfunction

  function automatic int opcode_of(input int kind);
    case (kind)
      0: return 0;   1: return 8;   2: return 13;  3: return 12;
      4: return 15;  5: return 35;  6: return 43;  7: return 4;
      8: return 5;   9: return 2;   10: return 3;
      default: return -1;
    endcase
  endfunction

  // Reference: word = op*2^26 + fields, branch offset counted in words from pc+4.
  task automatic model(input cmd_t c, input logic [31:0] pc, output logic [31:0] w, output int ec);
    int k, op, words;
    logic [31:0] diff;
    k = int'(c.kind);
    ec = 0;
    w = 32'd0;
    op = opcode_of(k);
    if (op < 0) begin
      ec = 1;
    end else if (k == 0) begin
      w = 32'(op) * 32'h0400_0000 + 32'(c.rs) * 32'h0020_0000 + 32'(c.rt) * 32'h0001_0000 +
          32'(c.rd) * 32'h800 + 32'(c.shamt) * 32'h40 + 32'(c.funct);
    end else if (k == 4) begin
      w = 32'(op) * 32'h0400_0000 + 32'(c.rt) * 32'h0001_0000 + 32'(c.imm);
    end else if (k == 7 || k == 8) begin
      diff  = c.target - (pc + 32'd4);
      words = $signed(diff) >>> 2;
      w = 32'(op) * 32'h0400_0000 + 32'(c.rs) * 32'h0020_0000 + 32'(c.rt) * 32'h0001_0000 +
          (32'(words) & 32'h0000_FFFF);
`ifdef ENC_RANGE_CHECK_EN
      if (words < -32768 || words > 32767 || c.target % 4 != 0) ec = 2;
`endif
    end else if (k == 9 || k == 10) begin
      w = 32'(op) * 32'h0400_0000 + ((c.target / 4) % 32'h0400_0000);
`ifdef ENC_RANGE_CHECK_EN
      if ((c.target / 32'h1000_0000) != ((pc + 32'd4) / 32'h1000_0000) || c.target % 4 != 0) ec = 3;
`endif
    end else begin
      w = 32'(op) * 32'h0400_0000 + 32'(c.rs) * 32'h0020_0000 + 32'(c.rt) * 32'h0001_0000 +
          32'(c.imm);
    end
  endtask

  task automatic present(input cmd_t c);
    cmd_valid = 1'b1; cmd_kind = c.kind; cmd_rs = c.rs; cmd_rt = c.rt; cmd_rd = c.rd;
    cmd_shamt = c.shamt; cmd_funct = c.funct; cmd_imm = c.imm; cmd_target = c.target;
    cmd_last = c.last;
  endtask

  task automatic send(input cmd_t c, input bit use_exp, input logic [31:0] exp_w);
    int n = 0;
    bit acc = 1'b0;
    logic [31:0] w;
    int ec;
    present(c);
    while (n < 300 && !acc) begin
      @(negedge clk);
      if (cmd_ready) acc = 1'b1;
      else n++;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 300 cycles");
    end else begin
      model(c, m_pc, w, ec);
      if (use_exp) w = exp_w;
      last_ec = ec;
      if (ec == 0) begin
        sb.push_back('{m_pc, w});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    sb.delete();
    m_pc = BASE;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (!done && k < 2000) begin
      @(negedge clk); k++;
    end
    chk("done", 32'(done), 32'd1);
    chk("word_count", 32'(word_count), 32'(n));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("err_clear", 32'(err), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_drained();
    int k = 0;
    while ((sb.size() != 0 || mem_we) && k < 200) begin
      @(negedge clk); k++;
    end
    repeat (2) @(negedge clk);
  endtask

  // Memory-side ready pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = ($urandom_range(0, 3) != 0);
        default: mem_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares each completed write and checks stability while stalled.
  bit          hold_pending = 1'b0;
  logic [31:0] hold_addr, hold_data;
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_we", 32'(mem_we), 32'd1);
        chk("hold_addr", mem_addr, hold_addr);
        chk("hold_wdata", mem_wdata, hold_data);
      end
      if (mem_we && mem_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.word);
        end
      end
      hold_pending = mem_we && !mem_ready;
      hold_addr = mem_addr;
      hold_data = mem_wdata;
    end
  end

  initial begin
    cmd_t c;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_done_err", 32'({done, err, err_code}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // ADDI then R-type add.
    do_start();
    send(mk(1, 0, 8, 0, 0, 0, 5, 32'd0, 1'b0), 1'b1, 32'h2008_0005);
    send(mk(0, 8, 9, 10, 0, 6'h20, 0, 32'd0, 1'b1), 1'b1, 32'h0109_5020);
    wait_done(2);

    // Backward BEQ from pc 0x00400008, then J.
    do_start();
    send(mk(1, 0, 8, 0, 0, 0, 1, 32'd0, 1'b0), 1'b0, 32'd0);
    send(mk(1, 0, 9, 0, 0, 0, 2, 32'd0, 1'b0), 1'b0, 32'd0);
    send(mk(7, 8, 9, 0, 0, 0, 0, 32'h0040_0000, 1'b0), 1'b1, 32'h1109_FFFD);
    send(mk(9, 0, 0, 0, 0, 0, 0, 32'h0040_0010, 1'b1), 1'b1, 32'h0810_0004);
    wait_done(4);

    // LUI ignores rs.
    do_start();
    send(mk(4, 5, 1, 0, 0, 0, 16'h1001, 32'd0, 1'b1), 1'b1, 32'h3C01_1001);
    wait_done(1);

    // Memory stalled: four accepts fill the buffer, the fifth waits.
    do_start();
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) send(mk(2, i, i + 1, 0, 0, 0, 16'h100 + i, 32'd0, 1'b0), 1'b0, 32'd0);
    c = mk(3, 7, 6, 0, 0, 0, 16'hBEEF, 32'd0, 1'b0);
    present(c);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("stall_mem_we", 32'(mem_we), 32'd1);
    end
    rdy_mode = 0;
    send(c, 1'b0, 32'd0);
    send(mk(6, 3, 4, 0, 0, 0, 16'h0040, 32'd0, 1'b1), 1'b0, 32'd0);
    wait_done(6);

    // Random program with in-range branches and in-region jumps.
    do_start();
    rdy_mode = 1;
    n = 60;
    for (int i = 0; i < n; i++) begin
      logic [31:0] tgt;
      int k;
      k = $urandom_range(0, 10);
      if (k == 7 || k == 8)
        tgt = m_pc + 32'd4 + 32'($urandom_range(0, 4000)) * 32'd4 - 32'd8000;
      else
        tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ($urandom & 32'h0FFF_FFFC);
      send(mk(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
              tgt, i == n - 1), 1'b0, 32'd0);
    end
    wait_done(n);
    rdy_mode = 0;

    // Far branch: error with range checks, truncated offset without.
    do_start();
    send(mk(7, 8, 9, 0, 0, 0, 0, 32'h0050_0000, 1'b1), 1'b1, 32'h1109_FFFF);
`ifdef ENC_RANGE_CHECK_EN
    wait_drained();
    chk("range_err", 32'(err), 32'd1);
    chk("range_err_code", 32'(err_code), 32'd2);
    chk("range_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("range_words", 32'(word_count), 32'd0);
`else
    wait_done(1);
`endif

    // Bad kind after one good word: the good word still drains.
    do_start();
    send(mk(1, 1, 2, 0, 0, 0, 16'h7FFF, 32'd0, 1'b0), 1'b0, 32'd0);
    send(mk(11, 0, 0, 0, 0, 0, 0, 32'd0, 1'b0), 1'b0, 32'd0);
    chk("bad_kind_model", 32'(last_ec), 32'd1);
    wait_drained();
    chk("bad_kind_err", 32'(err), 32'd1);
    chk("bad_kind_code", 32'(err_code), 32'd1);
    chk("bad_kind_ready", 32'(cmd_ready), 32'd0);
    chk("bad_kind_words", 32'(word_count), 32'd1);
    chk("bad_kind_done", 32'(done), 32'd0);

    // Reset while draining three queued words.
    do_start();
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) send(mk(5, i, i, 0, 0, 0, 4 * i, 32'd0, i == 2), 1'b0, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_count_flags", 32'({word_count, done, err, err_code}), 32'd0);
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_we", 32'(mem_we), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
